// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
package pll_lock_sequencer_pkg;

   localparam int DIV_W_DEF = 3;

   typedef enum logic [2:0] {
      ST_GATE,
      ST_PROGRAM,
      ST_WAIT_LOCK,
      ST_RUN,
      ST_ERROR
   } state_t;

   // Width of a counter that must hold values 0..n; never narrower than 1 bit.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pll_lock_sequencer_lock_qualifier.sv
// Lock qualification: consecutive-locked stable counter and per-attempt timeout counter.
module pll_lock_sequencer_lock_qualifier
   import pll_lock_sequencer_pkg::*;
#(
   parameter int STABLE_CYC  = 8,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   input  logic i_pll_locked,
   output logic o_stable_hit,
   output logic o_timeout_hit
);

   localparam int SW = cnt_w(STABLE_CYC);
   localparam int TW = cnt_w(TIMEOUT_CYC);

   logic [SW-1:0] r_stable;
   logic [TW-1:0] r_tmo;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_stable <= '0;
         r_tmo    <= '0;
      end else if (i_enable) begin
         r_stable <= i_pll_locked ? r_stable + SW'(1) : '0;
         r_tmo    <= r_tmo + TW'(1);
      end
   end

   // Hits fire on the cycle that completes the count, so the FSM moves on that same edge.
   assign o_stable_hit  = i_enable & i_pll_locked & (r_stable == SW'(STABLE_CYC - 1));
   assign o_timeout_hit = i_enable & (r_tmo == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/pll_lock_sequencer.sv
// Sequences pll_core reconfiguration: gate output, program divisor, qualify lock, re-enable.
module pll_lock_sequencer
   import pll_lock_sequencer_pkg::*;
#(
   parameter int               DIV_W       = DIV_W_DEF,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(1),
   parameter int               GATE_CYC    = 4,
   parameter int               STABLE_CYC  = 8,
   parameter int               TIMEOUT_CYC = 64,
   parameter int               MAX_RETRY   = 2
) (
   input  logic             i_clk_in,
   input  logic             i_rst,
   input  logic             i_req_valid,
   input  logic [DIV_W-1:0] i_req_div,
   output logic             o_req_ready,
   output logic             o_req_err,
   input  logic             i_pll_locked,
   output logic [DIV_W-1:0] o_div_num,
   output logic             o_clk_out_enable,
   output logic             o_lock_ok,
   output logic             o_err_timeout,
   output logic [7:0]       o_loss_cnt
);

   localparam int GW = cnt_w(GATE_CYC);
   localparam int RW = cnt_w(MAX_RETRY);

   state_t           r_state, w_state_nxt;
   logic [GW-1:0]    r_gate_cnt, w_gate_cnt_nxt;
   logic [RW-1:0]    r_retry, w_retry_nxt;
   logic [DIV_W-1:0] r_target, w_target_nxt;
   logic [DIV_W-1:0] r_div_num, w_div_nxt;
   logic [7:0]       r_loss_cnt, w_loss_nxt;
   logic             r_err_to, w_err_nxt;
   logic             r_req_err, w_req_err_nxt;
   logic             r_clk_en, r_lock_ok, r_req_ready;
   logic             w_stable_hit, w_timeout_hit, w_accept;

   pll_lock_sequencer_lock_qualifier #(
      .STABLE_CYC (STABLE_CYC),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_qual (
      .i_clk        (i_clk_in),
      .i_rst        (i_rst),
      .i_clear      (r_state == ST_PROGRAM),
      .i_enable     (r_state == ST_WAIT_LOCK),
      .i_pll_locked (i_pll_locked),
      .o_stable_hit (w_stable_hit),
      .o_timeout_hit(w_timeout_hit)
   );

   assign w_accept = i_req_valid & r_req_ready;

   always_comb begin
      w_state_nxt    = r_state;
      w_gate_cnt_nxt = '0;
      w_retry_nxt    = r_retry;
      w_target_nxt   = r_target;
      w_div_nxt      = r_div_num;
      w_loss_nxt     = r_loss_cnt;
      w_err_nxt      = r_err_to;
      w_req_err_nxt  = 1'b0;
      case (r_state)
         ST_GATE: begin
            if (r_gate_cnt == GW'(GATE_CYC - 1)) w_state_nxt = ST_PROGRAM;
            else w_gate_cnt_nxt = r_gate_cnt + GW'(1);
         end
         ST_PROGRAM: begin
            w_div_nxt   = r_target;
            w_state_nxt = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (w_stable_hit) begin
               w_state_nxt = ST_RUN;
            end else if (w_timeout_hit) begin
               if (r_retry < RW'(MAX_RETRY)) begin
                  w_retry_nxt = r_retry + RW'(1);
                  w_state_nxt = ST_GATE;
               end else begin
                  w_err_nxt   = 1'b1;
                  w_state_nxt = ST_ERROR;
               end
            end
         end
         ST_RUN: begin
            w_retry_nxt = '0;
            if (!i_pll_locked) begin
               if (r_loss_cnt != 8'hFF) w_loss_nxt = r_loss_cnt + 8'd1;
               w_state_nxt = ST_GATE;
            end
            if (w_accept) begin
               if (i_req_div == '0) begin
                  w_req_err_nxt = 1'b1;
               end else begin
                  w_target_nxt = i_req_div;
                  w_err_nxt    = 1'b0;
                  // Re-requesting the running divisor is a no-op unless lock was just lost.
                  if (i_req_div != r_div_num) w_state_nxt = ST_GATE;
               end
            end
         end
         ST_ERROR: begin
            if (w_accept) begin
               if (i_req_div == '0) begin
                  w_req_err_nxt = 1'b1;
               end else begin
                  w_target_nxt = i_req_div;
                  w_retry_nxt  = '0;
                  w_err_nxt    = 1'b0;
                  w_state_nxt  = ST_GATE;
               end
            end
         end
         default: w_state_nxt = ST_GATE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge i_clk_in) begin
      if (i_rst) begin
         r_state     <= ST_GATE;
         r_gate_cnt  <= '0;
         r_retry     <= '0;
         r_target    <= DEFAULT_DIV;
         r_div_num   <= DEFAULT_DIV;
         r_loss_cnt  <= '0;
         r_err_to    <= 1'b0;
         r_req_err   <= 1'b0;
         r_clk_en    <= 1'b0;
         r_lock_ok   <= 1'b0;
         r_req_ready <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_gate_cnt  <= w_gate_cnt_nxt;
         r_retry     <= w_retry_nxt;
         r_target    <= w_target_nxt;
         r_div_num   <= w_div_nxt;
         r_loss_cnt  <= w_loss_nxt;
         r_err_to    <= w_err_nxt;
         r_req_err   <= w_req_err_nxt;
         r_clk_en    <= (w_state_nxt == ST_RUN);
         r_lock_ok   <= (w_state_nxt == ST_RUN);
         r_req_ready <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_ERROR);
      end
   end

   assign o_req_ready      = r_req_ready;
   assign o_req_err        = r_req_err;
   assign o_div_num        = r_div_num;
   assign o_clk_out_enable = r_clk_en;
   assign o_lock_ok        = r_lock_ok;
   assign o_err_timeout    = r_err_to;
   assign o_loss_cnt       = r_loss_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: age-based behavioural model plus directed and random stimulus.
module tb_pll_lock_sequencer;

   localparam int         DIV_W       = 3;
   localparam logic [2:0] DEF_DIV     = 3'd1;
   localparam int         GATE_CYC    = 4;
   localparam int         STABLE_CYC  = 8;
   localparam int         TIMEOUT_CYC = 64;
   localparam int         MAX_RETRY   = 2;

   localparam int M_RC  = 0;   // reconfiguring: gating, programming, waiting for lock
   localparam int M_RUN = 1;
   localparam int M_ERR = 2;

   logic       clk = 1'b0;
   logic       rst, req_valid, pll_locked;
   logic [2:0] req_div;
   logic       o_req_ready, o_req_err, o_clk_out_enable, o_lock_ok, o_err_timeout;
   logic [2:0] o_div_num;
   logic [7:0] o_loss_cnt;

   always #5 clk = ~clk;

   pll_lock_sequencer #(
      .DIV_W(DIV_W), .DEFAULT_DIV(DEF_DIV), .GATE_CYC(GATE_CYC),
      .STABLE_CYC(STABLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .MAX_RETRY(MAX_RETRY)
   ) dut (
      .i_clk_in(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_div(req_div),
      .o_req_ready(o_req_ready), .o_req_err(o_req_err), .i_pll_locked(pll_locked),
      .o_div_num(o_div_num), .o_clk_out_enable(o_clk_out_enable), .o_lock_ok(o_lock_ok),
      .o_err_timeout(o_err_timeout), .o_loss_cnt(o_loss_cnt)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: age counts edges since a reconfiguration began; the divisor is programmed
   // on edge GATE_CYC+1 and lock is sought on the TIMEOUT_CYC edges after that.
   int         m_mode = M_RC;
   int         m_age = 0, m_rl = 0, m_tries = 0, m_loss = 0;
   logic [2:0] m_div = DEF_DIV, m_tgt = DEF_DIV;
   bit         m_rerr = 0;
   bit         started = 0;

   always @(posedge clk) begin
      bit restart;
      restart = 0;
      started = 1;
      if (rst) begin
         m_mode = M_RC; m_age = 0; m_rl = 0; m_tries = 0; m_loss = 0;
         m_div = DEF_DIV; m_tgt = DEF_DIV; m_rerr = 0;
      end else begin
         m_rerr = 0;
         case (m_mode)
            M_RC: begin
               m_age++;
               if (m_age == GATE_CYC + 1) m_div = m_tgt;
               else if (m_age > GATE_CYC + 1) begin
                  m_rl = pll_locked ? m_rl + 1 : 0;
                  if (m_rl == STABLE_CYC) begin
                     m_mode = M_RUN; m_tries = 0;
                  end else if (m_age - GATE_CYC - 1 == TIMEOUT_CYC) begin
                     if (m_tries < MAX_RETRY) begin m_tries++; restart = 1; end
                     else m_mode = M_ERR;
                  end
               end
            end
            M_RUN: begin
               if (!pll_locked) begin
                  if (m_loss < 255) m_loss++;
                  restart = 1;
               end
               if (req_valid) begin
                  if (req_div == 3'd0) m_rerr = 1;
                  else begin
                     m_tgt = req_div;
                     if (req_div != m_div) restart = 1;
                  end
               end
            end
            default: begin
               if (req_valid) begin
                  if (req_div == 3'd0) m_rerr = 1;
                  else begin m_tgt = req_div; m_tries = 0; restart = 1; end
               end
            end
         endcase
         if (restart) begin m_mode = M_RC; m_age = 0; m_rl = 0; end
      end
   end

   logic [2:0] prev_div = DEF_DIV;
   bit         prev_en = 0;
   bit         saw_lock = 0;

   always @(negedge clk) begin
      if (started) begin
         chk("div_num", o_div_num, m_div);
         chk("clk_out_enable", o_clk_out_enable, m_mode == M_RUN);
         chk("lock_ok", o_lock_ok, m_mode == M_RUN);
         chk("req_ready", o_req_ready, m_mode != M_RC);
         chk("req_err", o_req_err, m_rerr);
         chk("err_timeout", o_err_timeout, m_mode == M_ERR);
         chk("loss_cnt", o_loss_cnt, m_loss);
         chk("inv_div_while_enabled", (o_div_num != prev_div) && (prev_en || o_clk_out_enable), 0);
         chk("inv_lock_without_enable", o_lock_ok && !o_clk_out_enable, 0);
         if (o_lock_ok) saw_lock = 1;
         prev_div = o_div_num;
         prev_en  = o_clk_out_enable;
      end
   end

   // lk_mode: 0 tied high, 1 tied low, 2 chatter (5 high / 1 low), 3 random, 4 manual.
   int lk_mode = 0;
   int ch = 0;

   task automatic tick();
      @(negedge clk);
      case (lk_mode)
         0: pll_locked = 1'b1;
         1: pll_locked = 1'b0;
         2: begin pll_locked = (ch % 6) != 5; ch++; end
         3: pll_locked = ($urandom_range(0, 15) != 0);
         default: ;
      endcase
   endtask

   task automatic wait_mode(input int m, input int budget);
      for (int k = 0; k < budget && m_mode != m; k++) tick();
      chk("wait_mode_bound", m_mode, m);
   endtask

   task automatic send_req(input logic [2:0] d, output bit ok);
      bit rdy;
      ok = 0;
      req_valid = 1'b1;
      req_div   = d;
      for (int k = 0; k < 400 && !ok; k++) begin
         rdy = (m_mode != M_RC);
         tick();
         if (rdy) ok = 1;
      end
      req_valid = 1'b0;
      if (!ok) chk("req_accept_bound", 0, 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_div"}, o_div_num, DEF_DIV);
      chk({tag, "_en"}, o_clk_out_enable, 0);
      chk({tag, "_lock"}, o_lock_ok, 0);
      chk({tag, "_ready"}, o_req_ready, 0);
      chk({tag, "_rerr"}, o_req_err, 0);
      chk({tag, "_errto"}, o_err_timeout, 0);
      chk({tag, "_loss"}, o_loss_cnt, 0);
   endtask

   initial begin
      int n;
      bit ok;
      rst = 1'b1; req_valid = 1'b0; req_div = 3'd0; pll_locked = 1'b1;
      repeat (3) tick();
      check_reset("reset");
      rst = 1'b0;

      // Reset release with lock held high.
      n = 0;
      for (int k = 1; k <= 40 && n == 0; k++) begin
         tick();
         if (o_lock_ok) n = k;
      end
      chk("t1_lock_latency", n, GATE_CYC + 1 + STABLE_CYC);
      chk("t1_div", o_div_num, 1);

      // Divisor change from RUN.
      send_req(3'd3, ok);
      chk("t2_en_low_after_accept", o_clk_out_enable, 0);
      n = 0;
      for (int k = 1; k <= 20 && n == 0; k++) begin
         tick();
         if (o_div_num == 3'd3) n = k;
      end
      chk("t2_div_latency", n, GATE_CYC + 1);
      wait_mode(M_RUN, 100);
      chk("t2_relock", o_lock_ok, 1);

      // Lock lost for good: retries exhausted, then recovery by request.
      lk_mode = 1;
      wait_mode(M_ERR, 400);
      chk("t3_err", o_err_timeout, 1);
      chk("t3_en", o_clk_out_enable, 0);
      chk("t3_loss", o_loss_cnt, 1);
      lk_mode = 0;
      send_req(3'd2, ok);
      wait_mode(M_RUN, 100);
      chk("t3_err_cleared", o_err_timeout, 0);
      chk("t3_lock", o_lock_ok, 1);
      chk("t3_div", o_div_num, 2);

      // Chattering lock never qualifies.
      ch = 0;
      lk_mode = 2;
      wait_mode(M_RC, 20);
      saw_lock = 0;
      wait_mode(M_ERR, 400);
      chk("t4_never_locked", saw_lock, 0);
      chk("t4_err", o_err_timeout, 1);
      chk("t4_loss", o_loss_cnt, 2);
      lk_mode = 0;
      send_req(3'd3, ok);
      wait_mode(M_RUN, 100);

      // Repeated single-cycle lock drops saturate the loss counter.
      lk_mode = 4;
      pll_locked = 1'b1;
      for (int i = 0; i < 300; i++) begin
         wait_mode(M_RUN, 60);
         pll_locked = 1'b0;
         tick();
         pll_locked = 1'b1;
      end
      wait_mode(M_RUN, 60);
      chk("t5_loss_sat", o_loss_cnt, 255);
      chk("t5_div_same", o_div_num, 3);

      // Zero divisor is dropped with an error pulse.
      lk_mode = 0;
      send_req(3'd0, ok);
      chk("t6_req_err_pulse", o_req_err, 1);
      chk("t6_div_kept", o_div_num, 3);
      chk("t6_still_locked", o_lock_ok, 1);
      tick();
      chk("t6_req_err_clear", o_req_err, 0);

      // Reset in the middle of waiting for lock.
      lk_mode = 1;
      send_req(3'd5, ok);
      for (int k = 0; k < 40 && !(m_mode == M_RC && m_age >= GATE_CYC + 10); k++) tick();
      chk("t6_in_wait", m_age >= GATE_CYC + 10, 1);
      rst = 1'b1;
      tick();
      check_reset("t6_midrst");
      rst = 1'b0;
      lk_mode = 0;
      wait_mode(M_RUN, 100);
      chk("t6_div_default", o_div_num, DEF_DIV);

      // Random requests (including zero and repeats) against random lock behaviour.
      lk_mode = 3;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 30)) tick();
         send_req(3'($urandom_range(0, 7)), ok);
      end
      lk_mode = 0;
      repeat (5) tick();
      if (m_mode == M_ERR) send_req(3'd4, ok);
      wait_mode(M_RUN, 300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
